// File: rtl/multicycle_mem_responder.sv
// Memory-side responder for the multicycle core's shared instruction/data port.
// Accepts one request at a time, waits LATENCY cycles, then performs a
// byte/half/word load or store on an internal word-addressed RAM and returns a
// response that is held until the initiator consumes it.
// Optional build macro: MEM_RESPONDER_MISALIGN_TRAP_EN flags misaligned
// halfword/word accesses as errors instead of silently ignoring low address bits.
module multicycle_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error
);

  localparam int  DEPTH    = 1 << (ADDR_WIDTH - 2);
  localparam bit  ZERO_LAT = (LATENCY == 0);

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, next_state;
  logic [3:0]            counter;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [31:0]           wdata_q;

  logic [31:0] mem [DEPTH];

  logic                  accept, access, rsp_done;
  logic                  acc_write;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [2:0]            acc_funct3;
  logic [31:0]           acc_wdata;
  logic                  acc_err;
  logic [31:0]           rd_word, load_data, store_data;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [3:0]            byte_en;
  logic [1:0]            lane;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // With zero latency the access happens on the acceptance edge, so it must use
  // the live request; otherwise it uses the fields captured at acceptance.
  assign acc_write  = ZERO_LAT ? req_write  : write_q;
  assign acc_addr   = ZERO_LAT ? req_addr   : addr_q;
  assign acc_funct3 = ZERO_LAT ? req_funct3 : funct3_q;
  assign acc_wdata  = ZERO_LAT ? req_wdata  : wdata_q;
  assign lane       = acc_addr[1:0];
  assign rd_word    = mem[acc_addr[ADDR_WIDTH-1:2]];

  // Next-state logic and the one-cycle strobes for accept, access and handoff.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    access     = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (ZERO_LAT) begin
            access     = 1'b1;
            next_state = RESP;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (counter == 4'd1) begin
          access     = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Decode the size code: error detection, load extraction/extension and store lane merge.
  always_comb begin
    acc_err    = (acc_funct3 == 3'b011) || (acc_funct3 == 3'b110) || (acc_funct3 == 3'b111);
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    if (((acc_funct3 == F_H) || (acc_funct3 == F_HU)) && acc_addr[0])
      acc_err = 1'b1;
    if ((acc_funct3 == F_W) && (lane != 2'b00))
      acc_err = 1'b1;
`endif
    case (lane)
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half   = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_data  = 32'd0;
    store_data = acc_wdata;
    byte_en    = 4'b0000;
    case (acc_funct3)
      F_B: begin
        load_data  = {{24{sel_byte[7]}}, sel_byte};
        store_data = {4{acc_wdata[7:0]}};
        byte_en    = 4'b0001 << lane;
      end
      F_BU: load_data = {24'd0, sel_byte};
      F_H: begin
        load_data  = {{16{sel_half[15]}}, sel_half};
        store_data = {2{acc_wdata[15:0]}};
        byte_en    = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      F_HU: load_data = {16'd0, sel_half};
      F_W: begin
        load_data = rd_word;
        byte_en   = 4'b1111;
      end
      default: load_data = 32'd0;
    endcase
  end

  // RAM write port: only addressed bytes of a legal store, never while reset is asserted.
  always_ff @(posedge clock) begin
    if (reset && access && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[acc_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  // State register, request capture, latency counter and the held response.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      funct3_q  <= 3'd0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        write_q  <= req_write;
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
        counter  <= 4'(LATENCY);
      end else if (state == WAIT) begin
        counter <= counter - 4'd1;
      end
      if (access) begin
        rsp_rdata <= (acc_write || acc_err) ? 32'd0 : load_data;
        rsp_error <= acc_err;
      end else if (rsp_done) begin
        rsp_rdata <= 32'd0;
        rsp_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Scoreboard bench for multicycle_mem_responder (LATENCY=2, ADDR_WIDTH=12).
// Expected responses are queued when a request is issued; a monitor pops and
// compares whenever a response handoff is about to happen.
`timescale 1ns/1ps
module tb_multicycle_mem_responder;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_rdata_q [$];
  logic        exp_err_q   [$];
  string       exp_name_q  [$];

  multicycle_mem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  // Free-running core clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Monitor: on every falling edge where a handoff will occur, compare against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_rdata_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rsp actual rdata=%h err=%b expected no response", rsp_rdata, rsp_error);
        end else begin
          string       nm;
          logic [31:0] er;
          logic        ee;
          nm = exp_name_q.pop_front();
          er = exp_rdata_q.pop_front();
          ee = exp_err_q.pop_front();
          checkOutput({nm, "_rdata"}, rsp_rdata, er);
          checkOutput({nm, "_err"}, {31'd0, rsp_error}, {31'd0, ee});
        end
      end
    end
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input string name, input logic wr, input logic [11:0] addr,
                               input logic [2:0] f3, input logic [31:0] wd,
                               input logic [31:0] exp_rd, input logic exp_err, input bit expect_rsp);
    int cnt;
    if (expect_rsp) begin
      exp_name_q.push_back(name);
      exp_rdata_q.push_back(exp_rd);
      exp_err_q.push_back(exp_err);
    end
    @(negedge clock);
    req_write  = wr;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    req_valid  = 1'b1;
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 50) begin
      @(negedge clock);
      cnt++;
    end
    if (req_ready !== 1'b1) begin
      checkOutput({name, "_accept_timeout"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int cnt = 0;
    while (exp_rdata_q.size() != 0 && cnt < 60) begin
      @(negedge clock);
      cnt++;
    end
    if (exp_rdata_q.size() != 0)
      checkOutput("drain_timeout", exp_rdata_q.size(), 32'd0);
    @(negedge clock);
  endtask

  task automatic waitRspValid();
    int cnt = 0;
    @(negedge clock);
    while (rsp_valid !== 1'b1 && cnt < 40) begin
      @(negedge clock);
      cnt++;
    end
    if (rsp_valid !== 1'b1)
      checkOutput("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  // Directed stimulus sequence.
  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 12'h000;
    req_funct3 = F_W;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
    reset = 1'b1;

    // Store word and measure response latency relative to the acceptance edge.
    applyStimulus("sw_010", 1'b1, 12'h010, F_W, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("lat_cycle1_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("lat_cycle1_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    checkOutput("lat_cycle2_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clock);
    checkOutput("lat_cycle3_valid", {31'd0, rsp_valid}, 32'd1);
    waitDrain();

    applyStimulus("lw_010", 1'b0, 12'h010, F_W, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1); waitDrain();
    applyStimulus("sw0_010", 1'b1, 12'h010, F_W, 32'h0, 32'h0, 1'b0, 1'b1); waitDrain();
    applyStimulus("sb_013", 1'b1, 12'h013, F_B, 32'h00000080, 32'h0, 1'b0, 1'b1); waitDrain();
    applyStimulus("lb_013", 1'b0, 12'h013, F_B, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1); waitDrain();
    applyStimulus("lbu_013", 1'b0, 12'h013, F_BU, 32'h0, 32'h00000080, 1'b0, 1'b1); waitDrain();
    applyStimulus("lw_010b", 1'b0, 12'h010, F_W, 32'h0, 32'h80000000, 1'b0, 1'b1); waitDrain();

    applyStimulus("sw_020", 1'b1, 12'h020, F_W, 32'h12345678, 32'h0, 1'b0, 1'b1); waitDrain();
    applyStimulus("sh_022", 1'b1, 12'h022, F_H, 32'h00008001, 32'h0, 1'b0, 1'b1); waitDrain();
    applyStimulus("lh_022", 1'b0, 12'h022, F_H, 32'h0, 32'hFFFF8001, 1'b0, 1'b1); waitDrain();
    applyStimulus("lhu_022", 1'b0, 12'h022, F_HU, 32'h0, 32'h00008001, 1'b0, 1'b1); waitDrain();
    applyStimulus("lh_020", 1'b0, 12'h020, F_H, 32'h0, 32'h00005678, 1'b0, 1'b1); waitDrain();
    applyStimulus("lb_021", 1'b0, 12'h021, F_B, 32'h0, 32'h00000056, 1'b0, 1'b1); waitDrain();
    applyStimulus("lbu_022", 1'b0, 12'h022, F_BU, 32'h0, 32'h00000001, 1'b0, 1'b1); waitDrain();
    applyStimulus("lw_020", 1'b0, 12'h020, F_W, 32'h0, 32'h80015678, 1'b0, 1'b1); waitDrain();

    // Backpressure: response must hold and a competing request must wait.
    rsp_ready = 1'b0;
    applyStimulus("bp_lw_010", 1'b0, 12'h010, F_W, 32'h0, 32'h80000000, 1'b0, 1'b1);
    waitRspValid();
    req_write  = 1'b0;
    req_addr   = 12'h020;
    req_funct3 = F_W;
    req_wdata  = 32'h0;
    req_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_hold_rdata", rsp_rdata, 32'h80000000);
      checkOutput("bp_hold_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clock);
    #1 rsp_ready = 1'b1;
    applyStimulus("bp_lw_020", 1'b0, 12'h020, F_W, 32'h0, 32'h80015678, 1'b0, 1'b1);
    waitDrain();
    checkOutput("idle_rdata_cleared", rsp_rdata, 32'd0);
    checkOutput("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Illegal size codes leave memory untouched and flag an error.
    applyStimulus("sw_030", 1'b1, 12'h030, F_W, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1); waitDrain();
    applyStimulus("ill_st_030", 1'b1, 12'h030, 3'b011, 32'h11111111, 32'h0, 1'b1, 1'b1); waitDrain();
    applyStimulus("ill_ld_030", 1'b0, 12'h030, 3'b110, 32'h0, 32'h0, 1'b1, 1'b1); waitDrain();
    applyStimulus("lw_030", 1'b0, 12'h030, F_W, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1); waitDrain();
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    applyStimulus("lw_031", 1'b0, 12'h031, F_W, 32'h0, 32'h0, 1'b1, 1'b1); waitDrain();
    applyStimulus("lh_031", 1'b0, 12'h031, F_H, 32'h0, 32'h0, 1'b1, 1'b1); waitDrain();
`else
    applyStimulus("lw_031", 1'b0, 12'h031, F_W, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1); waitDrain();
    applyStimulus("lh_031", 1'b0, 12'h031, F_H, 32'h0, 32'hFFFFF00D, 1'b0, 1'b1); waitDrain();
`endif

    // Reset during WAIT discards the pending store.
    applyStimulus("sw_040", 1'b1, 12'h040, F_W, 32'h5555AAAA, 32'h0, 1'b0, 1'b1); waitDrain();
    applyStimulus("sw_040_abort", 1'b1, 12'h040, F_W, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b1;
    applyStimulus("lw_040", 1'b0, 12'h040, F_W, 32'h0, 32'h5555AAAA, 1'b0, 1'b1); waitDrain();

    repeat (4) @(negedge clock);
    checkOutput("scoreboard_empty", exp_rdata_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_mem_responder.md
Name: multicycle_mem_responder

Overview:
- Memory-side responder for the multicycle core's single shared instruction/data memory port; the core's control path is the initiator.
- Accepts one request at a time over a valid/ready handshake, waits a configurable number of cycles, performs the word/half/byte access on an internal word-addressed RAM, and returns a response.
- Load sign/zero extension and store byte-lane merging are done here, using RISC-V funct3 size codes.

Parameters:
- ADDR_WIDTH, 12, byte-address width; RAM depth is 2^(ADDR_WIDTH-2) 32-bit words.
- LATENCY, 2, wait cycles between request acceptance and response; legal range 0..15.

Ports:
- clock  in  1  core clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset; reset=0 at a rising edge resets the block.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load or fetch.
- req_addr  in  ADDR_WIDTH  byte address.
- req_funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU; instruction fetches use 010.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator consumes the response.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_error  out  1  illegal funct3 (011, 110, 111); also misaligned access when the optional feature is enabled.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (reset=0 at an edge):
  - state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - RAM contents are not reset.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch write/addr/funct3/wdata and load counter with LATENCY.
  - If LATENCY=0, go straight to the access step (same edge as RESP entry below, one cycle later); otherwise go to WAIT.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter==1, perform the access at that edge and enter RESP.
  - Total: acceptance edge N, rsp_valid first high in cycle N+LATENCY+1.
- Access step:
  - Word index = addr[ADDR_WIDTH-1:2]; lane = addr[1:0].
  - Loads: B/BU select byte lane, H/HU select halfword addr[1]; sign-extend for B/H, zero-extend for BU/HU; W returns the whole word.
  - Stores: merge only the addressed byte(s) into the RAM word; other bytes are unchanged.
  - Illegal funct3: no RAM write, rsp_rdata=0, rsp_error=1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_error are held stable until rsp_ready=1.
  - On rsp_ready=1: rsp_valid=0 next cycle, rsp_rdata/rsp_error cleared to 0, return to IDLE.
  - No request is accepted in the same cycle as the response handoff; minimum spacing between acceptances is LATENCY+2 cycles.
- Stable inputs: req_* is sampled only at the acceptance edge; later changes are ignored.
- Address wrap: addresses wrap modulo 2^ADDR_WIDTH (inherent in the width).
- Reset mid-operation: the FSM aborts immediately to IDLE. An access already committed at an edge before reset remains committed; a pending, not-yet-performed store is discarded.
- Read-after-write: a load issued after a store's response returns the stored value. No forwarding is needed because requests are serialized.

Optional Feature:
- Macro: MEM_RESPONDER_MISALIGN_TRAP_EN.
- Defined:
  - H/HU with addr[0]=1, or W with addr[1:0]!=0, is misaligned.
  - Misaligned accesses get rsp_error=1, rsp_rdata=0, and no RAM write.
  - Timing is unchanged.
- Undefined:
  - Misaligned H/HU uses halfword addr[1] (addr[0] ignored); misaligned W ignores addr[1:0].
  - rsp_error is set only for illegal funct3.

Test Plan:
- LATENCY=2: SW addr 0x010 data 0xDEADBEEF accepted at edge 0 -> rsp_valid high cycle 3, rsp_error=0; then LW 0x010 -> rsp_rdata=0xDEADBEEF.
- SB 0x013 data 0x80 over word 0x00000000 -> LB 0x013 returns 0xFFFFFF80, LBU 0x013 returns 0x00000080, LW 0x010 returns 0x80000000.
- SH 0x022 data 0x8001 -> LH 0x022 returns 0xFFFF8001, LHU returns 0x00008001; bytes 0x020-0x021 unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, a second req_valid is not accepted; release -> IDLE, then the second request is accepted.
- funct3=011 store to 0x030 -> rsp_error=1, rsp_rdata=0, later LW 0x030 shows the old contents; with MEM_RESPONDER_MISALIGN_TRAP_EN, LW 0x031 -> rsp_error=1.
- Assert reset=0 during WAIT of a SW 0x040 -> next cycle req_ready=1, rsp_valid=0, and LW 0x040 returns the prior value.
